// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the LC3 fetch
// and data paths; one transaction at a time with ack timeout and sticky err.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic              complete_instr,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_data,
  output logic [DATA_W-1:0] Data_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_data_q, last_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] idout_q, idout_d;
  logic [DATA_W-1:0] ddout_q, ddout_d;
  logic              cmp_i_q, cmp_i_d;
  logic              cmp_d_q, cmp_d_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      idout_q     <= '0;
      ddout_q     <= '0;
      cmp_i_q     <= 1'b0;
      cmp_d_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      idout_q     <= idout_d;
      ddout_q     <= ddout_d;
      cmp_i_q     <= cmp_i_d;
      cmp_d_q     <= cmp_d_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    idout_d     = idout_q;
    ddout_d     = ddout_q;
    cmp_i_d     = 1'b0;
    cmp_d_d     = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On contention the fetch wins only if data was served last.
        if (instrmem_rd && (!data_req || last_data_q)) begin
          state_d     = GRANT_I;
          last_data_d = 1'b0;
          addr_d      = pc;
          we_d        = 1'b0;
          wdata_d     = '0;
        end else if (data_req) begin
          state_d     = GRANT_D;
          last_data_d = 1'b1;
          addr_d      = Data_addr;
          we_d        = ~Data_rd;
          wdata_d     = Data_din;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack) begin
          state_d = DONE;
          if (state_q == GRANT_I) begin
            cmp_i_d = 1'b1;
            idout_d = mem_rdata;
          end else begin
            cmp_d_d = 1'b1;
            if (!we_q) ddout_d = mem_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (state_q == GRANT_I) begin
            cmp_i_d = 1'b1;
            idout_d = '0;
          end else begin
            cmp_d_d = 1'b1;
            if (!we_q) ddout_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req        = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign mem_we         = we_q & mem_req;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign complete_instr = cmp_i_q;
  assign complete_data  = cmp_d_q;
  assign Instr_dout     = idout_q;
  assign Data_dout      = ddout_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: inputs driven and outputs checked on the
// falling edge; the bench itself plays the memory.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        complete_instr;
  logic [15:0] Instr_dout;
  logic        complete_data;
  logic [15:0] Data_dout;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .complete_instr(complete_instr), .Instr_dout(Instr_dout),
    .complete_data(complete_data), .Data_dout(Data_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic exp_d;
    logic [15:0] rd;

    reset = 1'b1; instrmem_rd = 1'b0; pc = '0; data_req = 1'b0; Data_rd = 1'b0;
    Data_addr = '0; Data_din = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_cmp_i", {31'd0, complete_instr}, 32'd0);
    chk("rst_cmp_d", {31'd0, complete_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_idout", {16'd0, Instr_dout}, 32'd0);
    chk("rst_ddout", {16'd0, Data_dout}, 32'd0);
    chk("rst_we_addr", {15'd0, mem_we, mem_addr}, 32'd0);
    reset = 1'b0;

    // Fetch with zero-wait memory
    step();
    instrmem_rd = 1'b1; pc = 16'h3000;
    chk("f_no_comb_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("f_req", {31'd0, mem_req}, 32'd1);
    chk("f_addr", {16'd0, mem_addr}, 32'h3000);
    chk("f_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h1261;
    step();
    mem_ack = 1'b0;
    chk("f_cmp", {31'd0, complete_instr}, 32'd1);
    chk("f_dout", {16'd0, Instr_dout}, 32'h1261);
    chk("f_req_drop", {31'd0, mem_req}, 32'd0);
    chk("f_no_cmp_d", {31'd0, complete_data}, 32'd0);
    instrmem_rd = 1'b0;
    step();
    chk("f_cmp_1cyc", {31'd0, complete_instr}, 32'd0);

    // Data write with three wait cycles
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("w_req", {31'd0, mem_req}, 32'd1);
      chk("w_we", {31'd0, mem_we}, 32'd1);
      chk("w_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      chk("w_addr", {16'd0, mem_addr}, 32'h4000);
      chk("w_no_cmp", {31'd0, complete_data}, 32'd0);
      if (k == 3) begin mem_ack = 1'b1; mem_rdata = 16'hDEAD; end
    end
    step();
    mem_ack = 1'b0;
    chk("w_cmp", {31'd0, complete_data}, 32'd1);
    chk("w_ddout_kept", {16'd0, Data_dout}, 32'h0000);
    chk("w_idout_kept", {16'd0, Instr_dout}, 32'h1261);
    chk("w_req_drop", {31'd0, mem_req}, 32'd0);
    data_req = 1'b0;
    step();
    chk("w_cmp_1cyc", {31'd0, complete_data}, 32'd0);
    chk("w_err", {31'd0, err}, 32'd0);

    // Stray ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_ack = 1'b0;
    step();
    chk("stray_cmp", {30'd0, complete_instr, complete_data}, 32'd0);
    chk("stray_idout", {16'd0, Instr_dout}, 32'h1261);
    chk("stray_ddout", {16'd0, Data_dout}, 32'h0000);

    // Address FFFF passes through unchanged
    instrmem_rd = 1'b1; pc = 16'hFFFF;
    step();
    chk("wrap_addr", {16'd0, mem_addr}, 32'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    step();
    mem_ack = 1'b0; instrmem_rd = 1'b0;
    chk("wrap_dout", {16'd0, Instr_dout}, 32'h0F0F);
    step();

    // pc changes after grant; latched address must hold
    instrmem_rd = 1'b1; pc = 16'h3000;
    step();
    chk("chg_addr0", {16'd0, mem_addr}, 32'h3000);
    pc = 16'h3005;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("chg_addr_hold", {16'd0, mem_addr}, 32'h3000);
      chk("chg_req", {31'd0, mem_req}, 32'd1);
    end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0; instrmem_rd = 1'b0;
    chk("chg_cmp", {31'd0, complete_instr}, 32'd1);
    chk("chg_dout", {16'd0, Instr_dout}, 32'h5A5A);
    step();

    // Contention, last grant was a fetch: expect D, I, D, I
    instrmem_rd = 1'b1; pc = 16'h3100;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4100; Data_din = 16'h0000;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      rd = exp_d ? (16'hD000 + 16'(t)) : (16'h1000 + 16'(t));
      step();
      chk("c_req", {31'd0, mem_req}, 32'd1);
      chk("c_addr", {16'd0, mem_addr}, exp_d ? 32'h4100 : 32'h3100);
      chk("c_we", {31'd0, mem_we}, 32'd0);
      mem_ack = 1'b1; mem_rdata = rd;
      step();
      mem_ack = 1'b0;
      chk("c_cmp_d", {31'd0, complete_data}, {31'd0, exp_d});
      chk("c_cmp_i", {31'd0, complete_instr}, {31'd0, ~exp_d});
      chk("c_dout", {16'd0, exp_d ? Data_dout : Instr_dout}, {16'd0, rd});
      if (t == 3) begin instrmem_rd = 1'b0; data_req = 1'b0; end
      step();
      chk("c_pulse_1cyc", {30'd0, complete_instr, complete_data}, 32'd0);
    end
    chk("c_last_ddout", {16'd0, Data_dout}, 32'hD002);
    chk("c_last_idout", {16'd0, Instr_dout}, 32'h1003);

    // Timeout on a data read: mem_ack never comes
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4200;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("to_req", {31'd0, mem_req}, 32'd1);
    end
    step();
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_cmp", {31'd0, complete_data}, 32'd1);
    chk("to_dout", {16'd0, Data_dout}, 32'h0000);
    chk("to_err", {31'd0, err}, 32'd1);
    data_req = 1'b0;
    step();
    chk("to_cmp_1cyc", {31'd0, complete_data}, 32'd0);
    instrmem_rd = 1'b1; pc = 16'h3200;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    step();
    mem_ack = 1'b0; instrmem_rd = 1'b0;
    chk("to_fetch_ok", {16'd0, Instr_dout}, 32'h2222);
    step();
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset while a data transaction is in flight
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4300;
    step();
    chk("rm_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rm_req_async", {31'd0, mem_req}, 32'd0);
    chk("rm_err_async", {31'd0, err}, 32'd0);
    chk("rm_cmp_async", {30'd0, complete_instr, complete_data}, 32'd0);
    data_req = 1'b0;
    step();
    reset = 1'b0;
    chk("rm_idout", {16'd0, Instr_dout}, 32'h0000);
    step();
    instrmem_rd = 1'b1; pc = 16'h3000;
    chk("rm_no_cmp", {30'd0, complete_instr, complete_data}, 32'd0);
    step();
    chk("rm_f_req", {31'd0, mem_req}, 32'd1);
    chk("rm_f_addr", {16'd0, mem_addr}, 32'h3000);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_ack = 1'b0; instrmem_rd = 1'b0;
    chk("rm_f_cmp", {31'd0, complete_instr}, 32'd1);
    chk("rm_f_dout", {16'd0, Instr_dout}, 32'h7777);
    chk("rm_f_err", {31'd0, err}, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one single-port unified memory between the LC3 instruction-fetch path and its data-access path.
- Accepts fetch requests (instrmem_rd, pc) and data requests (data_req, Data_rd, Data_addr, Data_din).
- Sequences one memory transaction at a time and returns complete_instr / complete_data with read data.
- Sits between the LC3 core and the memory model, replacing per-port memory handling in the bench driver.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, max cycles to wait for mem_ack before aborting a transaction. Legal range 1..255.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- reset, in, 1, asynchronous active-high reset.
- instrmem_rd, in, 1, fetch request level; held until complete_instr.
- pc, in, ADDR_W, fetch address.
- data_req, in, 1, data request level; held until complete_data.
- Data_rd, in, 1, 1 = data read, 0 = data write.
- Data_addr, in, ADDR_W, data address.
- Data_din, in, DATA_W, write data.
- complete_instr, out, 1, one-cycle fetch completion pulse.
- Instr_dout, out, DATA_W, fetched instruction.
- complete_data, out, 1, one-cycle data completion pulse; pulses for both reads and writes.
- Data_dout, out, DATA_W, data read result.
- mem_req, out, 1, memory request; held until mem_ack or timeout.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data; valid when mem_ack = 1.
- mem_ack, in, 1, memory acknowledge; single-cycle.
- err, out, 1, sticky timeout flag.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0. FSM goes to IDLE. Timeout counter clears. Last-grant register is set to INSTR.
  - Reset asserted mid-transaction drops mem_req in the same cycle, with no completion pulse.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - Samples requests each cycle.
  - Only one of instrmem_rd / data_req asserted: grant it.
  - Both asserted: grant the requester opposite to the last grant (round-robin). A data request therefore never waits behind more than one fetch, and vice versa.
  - Transition to GRANT_I or GRANT_D; mem_req rises on the next cycle.
- GRANT_x:
  - Drives mem_req = 1. Latches address, we and wdata at grant; they are stable for the whole transaction even if the requester's inputs change.
  - Fetch: mem_we = 0, mem_addr = pc.
  - Data: mem_we = ~Data_rd, mem_addr = Data_addr, mem_wdata = Data_din.
  - Counter increments each cycle without mem_ack.
  - On mem_ack: deassert mem_req. For reads, register mem_rdata into Instr_dout or Data_dout. Pulse the matching complete_* for exactly one cycle (the cycle after ack). Go to DONE.
  - On reaching TIMEOUT cycles without ack: set err, deassert mem_req, pulse complete_* with dout = 16'h0000, go to DONE.
- DONE:
  - One bubble cycle. Lets the requester drop its request level before re-arbitration, so a stale level is not double-served.
  - Returns to IDLE.
- Latency: request seen in IDLE at cycle N; mem_req high at N+1. Ack at N+1 (zero-wait memory) gives complete at N+2. Minimum request-to-request spacing is 3 cycles.
- Data_dout and Instr_dout hold their last value until the next completion of the same type. Writes do not alter Data_dout.
- Data writes with Data_rd = 0 never update Instr_dout. Fetches never update Data_dout.
- mem_ack outside GRANT_x is ignored.
- err is cleared only by reset.
- Address wrap: 16'hFFFF is passed through unchanged; no arithmetic is performed on addresses.

Test Plan:
- Fetch only: reset 2 cycles, instrmem_rd = 1, pc = 16'h3000, memory acks in the same cycle as mem_req with 16'h1261 -> mem_req at N+1, complete_instr pulse at N+2, Instr_dout = 16'h1261, mem_we = 0.
- Data write: data_req = 1, Data_rd = 0, Data_addr = 16'h4000, Data_din = 16'hBEEF, ack after 3 waits -> mem_we = 1 and mem_wdata = 16'hBEEF held for 4 cycles, then one complete_data pulse, Data_dout unchanged.
- Contention: instrmem_rd and data_req held together for 4 transactions, last grant = INSTR -> grant order D, I, D, I; each complete pulse is exactly one cycle.
- Timeout: TIMEOUT = 15, mem_ack never asserted -> mem_req high for 15 cycles, then complete_data pulse with Data_dout = 16'h0000, err = 1 and staying 1 until reset.
- Reset mid-transaction: assert reset while in GRANT_D with mem_req = 1 -> mem_req, complete_* and err go to 0 asynchronously. After release, the first request at pc = 16'h3000 is served normally.
- Input change after grant: change pc from 16'h3000 to 16'h3005 while mem_req is high -> mem_addr stays 16'h3000 until ack.
